// File: rtl/time_report_tx_pkg.sv
// time_report_tx_pkg: FSM encoding, ASCII constants and frame lengths for the time report sender.
package time_report_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_DONE} state_t;
  localparam logic [7:0] A_ZERO  = 8'h30;
  localparam logic [7:0] A_COLON = 8'h3A;
  localparam logic [7:0] A_DOT   = 8'h2E;
  localparam logic [7:0] A_SPACE = 8'h20;
  localparam logic [7:0] A_R     = 8'h52;
  localparam logic [7:0] A_S     = 8'h53;
  localparam logic [7:0] A_CR    = 8'h0D;
  localparam logic [7:0] A_LF    = 8'h0A;
  localparam int FRAME_LEN_NOCRLF = 13;
  localparam int FRAME_LEN_CRLF   = 15;
endpackage

// File: rtl/time_report_tx_if.sv
// time_report_tx_if: byte handshake between the report sender and a UART transmitter.
interface time_report_tx_if;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy;
  logic       tx_done;
  modport master (output tx_start, tx_data, input tx_busy, tx_done);
  modport slave  (input tx_start, tx_data, output tx_busy, tx_done);
endinterface

// File: rtl/time_report_tx_bin2ascii2.sv
// bin2ascii2: saturates a 7-bit value to i_max and splits it into two ASCII decimal digits.
module bin2ascii2
  import time_report_tx_pkg::*;
(
  input  logic [6:0] i_val,
  input  logic [6:0] i_max,
  output logic [7:0] o_tens,
  output logic [7:0] o_ones
);
  logic [6:0] w_sat;
  assign w_sat  = (i_val > i_max) ? i_max : i_val;
  assign o_tens = A_ZERO + {1'b0, w_sat / 7'd10};
  assign o_ones = A_ZERO + {1'b0, w_sat % 7'd10};
endmodule

// File: rtl/time_report_tx.sv
// time_report_tx: sends a stopwatch snapshot "HH:MM:SS.CC X" (+ optional CR LF) byte by byte to a UART.
module time_report_tx
  import time_report_tx_pkg::*;
#(
  parameter bit CRLF_EN    = 1'b1,
  parameter int CLK_HZ     = 100_000_000,
  parameter int TIMEOUT_US = 2000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_req,
  input  logic                    i_run,
  input  logic [4:0]              i_hour,
  input  logic [5:0]              i_min,
  input  logic [5:0]              i_sec,
  input  logic [6:0]              i_cs,
  time_report_tx_if.master        uart,
  output logic                    o_busy,
  output logic                    o_frame_done,
  output logic                    o_error
);
  localparam int WD = CLK_HZ / 1_000_000 * TIMEOUT_US;
  localparam int WD_W = $clog2(WD + 1);
  localparam logic [3:0] LAST = 4'((CRLF_EN ? FRAME_LEN_CRLF : FRAME_LEN_NOCRLF) - 1);
  state_t r_state, w_next;
  logic r_pending, r_run, w_tx_start, w_error;
  logic [4:0] r_hour;
  logic [5:0] r_min, r_sec;
  logic [6:0] r_cs;
  logic [3:0] r_idx;
  logic [WD_W-1:0] r_wdog;
  logic [7:0] w_h1, w_h0, w_m1, w_m0, w_s1, w_s0, w_c1, w_c0;
  logic [15:0][7:0] w_frame;
  bin2ascii2 u_hour (.i_val({2'b00, r_hour}), .i_max(7'd23), .o_tens(w_h1), .o_ones(w_h0));
  bin2ascii2 u_min  (.i_val({1'b0, r_min}),   .i_max(7'd59), .o_tens(w_m1), .o_ones(w_m0));
  bin2ascii2 u_sec  (.i_val({1'b0, r_sec}),   .i_max(7'd59), .o_tens(w_s1), .o_ones(w_s0));
  bin2ascii2 u_cs   (.i_val(r_cs),            .i_max(7'd99), .o_tens(w_c1), .o_ones(w_c0));
  // index 0 sits in the low byte; entry 15 is padding so the 4-bit index never leaves the array
  assign w_frame = {8'h00, A_LF, A_CR, r_run ? A_R : A_S, A_SPACE, w_c0, w_c1, A_DOT,
                    w_s0, w_s1, A_COLON, w_m0, w_m1, A_COLON, w_h0, w_h1};
  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    w_error    = 1'b0;
    case (r_state)
      S_IDLE: w_next = (i_req || r_pending) ? S_LOAD : S_IDLE;
      S_LOAD: w_next = S_SEND;
      S_SEND: begin
        w_tx_start = !uart.tx_busy;
        w_next     = uart.tx_busy ? S_SEND : S_WAIT;
      end
      S_WAIT: begin
        w_error = !uart.tx_done && (r_wdog == WD_W'(WD - 1));
        w_next  = uart.tx_done ? ((r_idx == LAST) ? S_DONE : S_SEND) : (w_error ? S_IDLE : S_WAIT);
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_run     <= 1'b0;
      r_hour    <= '0;
      r_min     <= '0;
      r_sec     <= '0;
      r_cs      <= '0;
      r_idx     <= '0;
      r_wdog    <= '0;
    end else begin
      r_state   <= w_next;
      r_pending <= (r_state != S_IDLE) && !w_error && (r_pending || i_req);
      r_wdog    <= (r_state == S_WAIT) ? r_wdog + WD_W'(1) : '0;
      if (r_state == S_LOAD) begin
        r_run  <= i_run;
        r_hour <= i_hour;
        r_min  <= i_min;
        r_sec  <= i_sec;
        r_cs   <= i_cs;
        r_idx  <= '0;
      end else if (r_state == S_WAIT && uart.tx_done) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end
  assign uart.tx_start = w_tx_start;
  assign uart.tx_data  = (r_state == S_SEND || r_state == S_WAIT) ? w_frame[r_idx] : 8'h00;
  assign o_busy        = r_state != S_IDLE;
  assign o_frame_done  = r_state == S_DONE;
  assign o_error       = w_error;
endmodule

// File: tb/tb_time_report_tx.sv
// tb_time_report_tx: scoreboard bench for time_report_tx with a UART responder model.
module tb_time_report_tx;
  logic clk = 1'b0, rst = 1'b1, req = 1'b0, run = 1'b0;
  logic [4:0] hour = '0;
  logic [5:0] min = '0, sec = '0;
  logic [6:0] cs = '0;
  logic busy, frame_done, error;
  int n_checks = 0, n_pass = 0, n_starts = 0, n_frames = 0, resp_cnt = 0;
  bit withhold = 1'b0, inflight = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] cur, exp_b;

  time_report_tx_if uart();

  time_report_tx #(.CRLF_EN(1'b1), .CLK_HZ(100_000_000), .TIMEOUT_US(1)) dut (
    .clk(clk), .rst(rst), .i_req(req), .i_run(run), .i_hour(hour), .i_min(min),
    .i_sec(sec), .i_cs(cs), .uart(uart), .o_busy(busy), .o_frame_done(frame_done), .o_error(error)
  );

  always #5 clk = ~clk;

  // UART model: tx_done 10 cycles after each tx_start unless withheld
  initial begin
    uart.tx_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (rst) begin
        resp_cnt = 0;
        uart.tx_done = 1'b0;
      end else begin
        uart.tx_done = 1'b0;
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) uart.tx_done = 1'b1;
        end else if (uart.tx_start && !withhold) resp_cnt = 10;
      end
    end
  end

  // scoreboard: every launched byte is popped and compared, and must hold until tx_done
  initial forever begin
    @(negedge clk);
    if (rst) inflight = 1'b0;
    else begin
      if (uart.tx_done && inflight) begin
        n_checks++;
        if (uart.tx_data !== cur) $display("FAIL byte_stable: got %h want %h", uart.tx_data, cur);
        else n_pass++;
        inflight = 1'b0;
      end
      if (error) inflight = 1'b0;
      if (uart.tx_start) begin
        n_starts++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL unexpected_tx_start: got %h want none", uart.tx_data);
        else begin
          exp_b = exp_q.pop_front();
          if (uart.tx_data !== exp_b) $display("FAIL frame_byte: got %h want %h", uart.tx_data, exp_b);
          else n_pass++;
        end
        cur = uart.tx_data;
        inflight = 1'b1;
      end
      if (frame_done) n_frames++;
    end
  end

  function automatic logic [7:0] dig(int v, bit tens);
    return 8'(48 + (tens ? v / 10 : v % 10));
  endfunction

  task automatic push_frame(int h, int m, int s, int c, bit r);
    int hs = (h > 23) ? 23 : h;
    int ms = (m > 59) ? 59 : m;
    int ss = (s > 59) ? 59 : s;
    int cc = (c > 99) ? 99 : c;
    exp_q.push_back(dig(hs, 1)); exp_q.push_back(dig(hs, 0)); exp_q.push_back(8'h3A);
    exp_q.push_back(dig(ms, 1)); exp_q.push_back(dig(ms, 0)); exp_q.push_back(8'h3A);
    exp_q.push_back(dig(ss, 1)); exp_q.push_back(dig(ss, 0)); exp_q.push_back(8'h2E);
    exp_q.push_back(dig(cc, 1)); exp_q.push_back(dig(cc, 0)); exp_q.push_back(8'h20);
    exp_q.push_back(r ? 8'h52 : 8'h53); exp_q.push_back(8'h0D); exp_q.push_back(8'h0A);
  endtask

  task automatic set_time(int h, int m, int s, int c, bit r);
    hour = 5'(h); min = 6'(m); sec = 6'(s); cs = 7'(c); run = r;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1 req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
  endtask

  task automatic wait_frames(int target, int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_frames >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (uart.tx_start !== 1'b0) $display("FAIL reset_tx_start: got %b want 0", uart.tx_start); else n_pass++;
    n_checks++; if (uart.tx_data !== 8'h00) $display("FAIL reset_tx_data: got %h want 00", uart.tx_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
    n_checks++; if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error); else n_pass++;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || n_starts != 0) $display("FAIL reset_idle: busy %b starts %0d want 0 0", busy, n_starts); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] bytes [15] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h3A, 8'h35, 8'h36,
                               8'h2E, 8'h37, 8'h38, 8'h20, 8'h52, 8'h0D, 8'h0A};
    int f0 = n_frames;
    bit ok;
    foreach (bytes[i]) exp_q.push_back(bytes[i]);
    set_time(12, 34, 56, 78, 1'b1);
    pulse_req();
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || uart.tx_start !== 1'b0) $display("FAIL basic_load: busy %b tx_start %b want 1 0", busy, uart.tx_start); else n_pass++;
    @(negedge clk);
    n_checks++; if (uart.tx_start !== 1'b1) $display("FAIL basic_latency: tx_start %b want 1", uart.tx_start); else n_pass++;
    wait_frames(f0 + 1, 1000, ok);
    n_checks++; if (!ok) $display("FAIL basic_frame_done: got timeout want frame_done"); else n_pass++;
    repeat (100) @(negedge clk);
    n_checks++; if (n_frames != f0 + 1 || exp_q.size() != 0 || busy !== 1'b0)
      $display("FAIL basic_end: frames %0d left %0d busy %b want %0d 0 0", n_frames - f0, exp_q.size(), busy, 1); else n_pass++;
  endtask

  task automatic test_snapshot();
    int f0 = n_frames;
    bit ok;
    set_time(0, 0, 9, 99, 1'b0);
    push_frame(0, 0, 9, 99, 1'b0);
    pulse_req();
    repeat (30) @(posedge clk);
    #1 set_time(0, 0, 10, 0, 1'b1);
    wait_frames(f0 + 1, 1000, ok);
    n_checks++; if (!ok || exp_q.size() != 0) $display("FAIL snapshot_frame: done %b left %0d want 1 0", ok, exp_q.size()); else n_pass++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_busy_hold();
    int s0 = n_starts, f0 = n_frames;
    bit ok;
    set_time(1, 2, 3, 4, 1'b0);
    push_frame(1, 2, 3, 4, 1'b0);
    @(posedge clk); #1 uart.tx_busy = 1'b1;
    pulse_req();
    repeat (50) @(negedge clk);
    n_checks++; if (n_starts != s0 || busy !== 1'b1) $display("FAIL busy_hold: starts %0d busy %b want 0 1", n_starts - s0, busy); else n_pass++;
    @(posedge clk); #1 uart.tx_busy = 1'b0;
    @(negedge clk);
    n_checks++; if (uart.tx_start !== 1'b1 || uart.tx_data !== 8'h30) $display("FAIL busy_release: tx_start %b data %h want 1 30", uart.tx_start, uart.tx_data); else n_pass++;
    wait_frames(f0 + 1, 1000, ok);
    n_checks++; if (!ok || exp_q.size() != 0) $display("FAIL busy_frame: done %b left %0d want 1 0", ok, exp_q.size()); else n_pass++;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int s0 = n_starts, f0 = n_frames;
    bit ok;
    set_time(23, 59, 59, 50, 1'b1);
    push_frame(23, 59, 59, 50, 1'b1);
    pulse_req();
    repeat (5) @(posedge clk);
    #1 set_time(31, 63, 45, 120, 1'b0);
    push_frame(31, 63, 45, 120, 1'b0);
    repeat (3) begin
      pulse_req();
      repeat (7) @(posedge clk);
    end
    wait_frames(f0 + 2, 2000, ok);
    n_checks++; if (!ok) $display("FAIL b2b_frames: got timeout want two frames"); else n_pass++;
    repeat (300) @(negedge clk);
    n_checks++; if (n_frames != f0 + 2 || n_starts != s0 + 30 || exp_q.size() != 0)
      $display("FAIL b2b_count: frames %0d starts %0d want 2 30", n_frames - f0, n_starts - s0); else n_pass++;
  endtask

  task automatic test_timeout();
    int s0, f0 = n_frames, k = 0;
    bit found = 1'b0;
    withhold = 1'b1;
    set_time(5, 6, 7, 8, 1'b1);
    push_frame(5, 6, 7, 8, 1'b1);
    pulse_req();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart.tx_start) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) $display("FAIL timeout_start: got no tx_start want one"); else n_pass++;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      k++;
      if (error) break;
    end
    n_checks++; if (error !== 1'b1 || k != 100) $display("FAIL timeout_cycles: error %b after %0d want 1 100", error, k); else n_pass++;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || error !== 1'b0) $display("FAIL timeout_abort: busy %b error %b want 0 0", busy, error); else n_pass++;
    exp_q.delete();
    s0 = n_starts;
    repeat (200) @(negedge clk);
    n_checks++; if (n_starts != s0 || n_frames != f0) $display("FAIL timeout_quiet: starts %0d frames %0d want 0 0", n_starts - s0, n_frames - f0); else n_pass++;
    withhold = 1'b0;
  endtask

  task automatic test_reset_mid();
    int s0 = n_starts, f0;
    bit found = 1'b0, ok;
    set_time(10, 20, 30, 40, 1'b1);
    push_frame(10, 20, 30, 40, 1'b1);
    pulse_req();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (n_starts == s0 + 6) begin found = 1'b1; break; end
    end
    n_checks++; if (!found) $display("FAIL rstmid_reach: starts %0d want 6", n_starts - s0); else n_pass++;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_checks++; if (uart.tx_start !== 1'b0 || uart.tx_data !== 8'h00 || busy !== 1'b0 || frame_done !== 1'b0 || error !== 1'b0)
      $display("FAIL rstmid_outputs: start %b data %h busy %b fd %b err %b want 0 00 0 0 0", uart.tx_start, uart.tx_data, busy, frame_done, error); else n_pass++;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    s0 = n_starts;
    f0 = n_frames;
    repeat (50) @(negedge clk);
    n_checks++; if (n_starts != s0 || busy !== 1'b0) $display("FAIL rstmid_idle: starts %0d busy %b want 0 0", n_starts - s0, busy); else n_pass++;
    set_time(9, 8, 7, 6, 1'b0);
    push_frame(9, 8, 7, 6, 1'b0);
    pulse_req();
    wait_frames(f0 + 1, 1000, ok);
    n_checks++; if (!ok || exp_q.size() != 0 || n_starts != s0 + 15)
      $display("FAIL rstmid_refire: done %b starts %0d want 1 15", ok, n_starts - s0); else n_pass++;
  endtask

  initial begin
    uart.tx_busy = 1'b0;
    test_reset();
    test_basic();
    test_snapshot();
    test_busy_hold();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
